branch_hazard_ctrl: RTL and testbench
=====================================

// Module: branch_hazard_ctrl
// PURPOSE
// - Sequences branch/jump resolution in decode. Watches the source registers of the decode-stage branch (BV_* from mips.h).
// - Stalls IF/ID while EX/MEM producers are in flight; selects MEM->decode forwarding; squashes the IF/ID slot when the branch redirects.
// - Keeps saturating branch performance counters. Sits beside jump_unit and consumes its pc_src.
// PARAMETERS
// - CNT_W  32  width of each performance counter
// PORTS
// clk             in   1      clock; all state on rising edge
// rst_n           in   1      reset, synchronous, active-low
// branch_variant  in   3      decode-stage BV_* code
// id_rs           in   5      decode rs field
// id_rt           in   5      decode rt field
// pc_src          in   1      jump_unit taken decision (x when BV_NONE)
// ex_reg_write    in   1      EX instr writes a register
// ex_mem_to_reg   in   1      EX instr is a load
// ex_write_reg    in   5      EX destination register
// mem_reg_write   in   1      MEM instr writes a register
// mem_mem_to_reg  in   1      MEM instr is a load
// mem_write_reg   in   5      MEM destination register
// stall_f         out  1      hold PC
// stall_d         out  1      hold IF/ID
// flush_e         out  1      bubble into ID/EX
// flush_d         out  1      squash IF/ID (taken redirect)
// fwd_rs_d        out  1      1 = rs comparator takes MEM ALU result
// fwd_rt_d        out  1      1 = rt comparator takes MEM ALU result
// branch_cnt      out  CNT_W  resolved branch/jump count
// taken_cnt       out  CNT_W  redirects performed
// stall_cnt       out  CNT_W  branch stall cycles
// BEHAVIOUR
// - Operand use: rs used for JUMP_REG, BEQ, BNE, BLTZ; rt used for BEQ, BNE only.
// - JUMP, JUMP_LINK and NONE use no operands. A register number of 0 never hazards.
// - Per-operand need, computed combinationally:
//   * ex hit + load -> 2
//   * ex hit + ALU -> 1
//   * mem hit + load -> 1
//   * mem hit + ALU -> 0 with fwd=1
//   * otherwise 0.
//   need = max(rs_need, rt_need).
// - FSM IDLE/STALL, with a 2-bit countdown cnt.
// - IDLE:
//   * need==0: resolve this cycle.
//   * need>0: assert stall_f/stall_d/flush_e this cycle, cnt<=need-1, state<=STALL if need>1, else stay IDLE.
//   * The instruction re-evaluates next cycle; the pipeline has advanced, so need drops.
// - STALL: stall_f/stall_d/flush_e=1 and cnt decrements. At cnt==0 return to IDLE, where operands re-check and resolve.
// - Resolve cycle (IDLE, need==0, branch_variant!=BV_NONE):
//   * fwd_* per mem ALU hit
//   * flush_d=pc_src
//   * branch_cnt++, plus taken_cnt++ if pc_src.
// - Each asserted stall cycle: stall_cnt++.
// - BV_NONE in IDLE: all control outputs 0 and no counting; pc_src is ignored (x-safe).
// - BV_NONE seen in STALL (illegal): go to IDLE next cycle and drop the stall.
// - EX and MEM both hit the same register: the EX hit wins (youngest producer).
// - Counters saturate at all-ones; no wrap.
// - Reset:
//   * While rst_n==0, control outputs are forced 0.
//   * On the clock edge: state<=IDLE, cnt<=0, counters<=0.
//   * Reset mid-STALL abandons the stall; the held instruction re-evaluates after reset.
// - Latency: control outputs are Mealy (same cycle as the inputs); counters update on the next edge.
// STRUCTURE
// - mips.h gains:
//   * `BHC_IDLE/`BHC_STALL state codes
//   * `BR_MAX_STALL=2
//   * `BV_USES_RS(v)/`BV_USES_RT(v) macros; BV_* codes unchanged.
// - Sub-module branch_src_hazard: one operand's need[1:0] and fwd. Instantiated twice (rs, rt).
// - The top level holds the FSM, the outputs and three saturating counters.
// TESTING
// - BEQ rs=8, rt=9; EX ALU writes r8:
//   * cycle0: stall_f=stall_d=flush_e=1
//   * cycle1 (r8 in MEM): fwd_rs_d=1; pc_src=1 -> flush_d=1
//   * branch_cnt=1, taken_cnt=1, stall_cnt=1
// - BNE rt=5 with an EX load to r5: exactly 2 stall cycles, then resolve with fwd_rt_d=0; stall_cnt=2.
// - BLTZ rs=0 with EX ALU writing r0: no stall, resolves cycle0.
// - JUMP with EX load to any id_rs: no stall, flush_d=1, taken_cnt++.
// - rst_n=0 during the 2nd cycle of a load stall:
//   * outputs 0 that cycle
//   * state IDLE and counters 0 next cycle
//   * branch re-stalls for 1 cycle (load now in MEM).
// - CNT_W=4, 20 taken jumps: branch_cnt=taken_cnt=15 (saturated).

Source files
------------

// File: rtl/branch_hazard_ctrl_pkg.sv
// branch_hazard_ctrl_pkg: branch variant codes, FSM states and operand-use helpers
package branch_hazard_ctrl_pkg;
  typedef enum logic [2:0] {
    BV_NONE, BV_JUMP, BV_JUMP_LINK, BV_JUMP_REG, BV_BEQ, BV_BNE, BV_BLTZ
  } bv_t;
  typedef enum logic {BHC_IDLE, BHC_STALL} bhc_state_t;
  localparam int BR_MAX_STALL = 2;
  function automatic logic bv_uses_rs(bv_t v);
    return v inside {BV_JUMP_REG, BV_BEQ, BV_BNE, BV_BLTZ};
  endfunction
  function automatic logic bv_uses_rt(bv_t v);
    return v inside {BV_BEQ, BV_BNE};
  endfunction
endpackage

// File: rtl/branch_hazard_ctrl_src_hazard.sv
// branch_src_hazard: stall need and MEM forwarding for one decode-stage branch operand
module branch_src_hazard (
  input  logic       used,
  input  logic [4:0] src,
  input  logic       ex_reg_write,
  input  logic       ex_mem_to_reg,
  input  logic [4:0] ex_write_reg,
  input  logic       mem_reg_write,
  input  logic       mem_mem_to_reg,
  input  logic [4:0] mem_write_reg,
  output logic [1:0] need,
  output logic       fwd
);
  logic ex_hit, mem_hit;
  always_comb begin
    ex_hit  = used && src != 5'd0 && ex_reg_write && ex_write_reg == src;
    mem_hit = used && src != 5'd0 && mem_reg_write && mem_write_reg == src && !ex_hit;
    need    = ex_hit ? (ex_mem_to_reg ? 2'd2 : 2'd1) : (mem_hit && mem_mem_to_reg ? 2'd1 : 2'd0);
    fwd     = mem_hit && !mem_mem_to_reg;
  end
endmodule

// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: decode-stage branch stall/forward/squash sequencing with saturating counters
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       branch_variant,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             pc_src,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_reg_write,
  input  logic             mem_mem_to_reg,
  input  logic [4:0]       mem_write_reg,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output logic             flush_d,
  output logic             fwd_rs_d,
  output logic             fwd_rt_d,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int CW = $clog2(BR_MAX_STALL + 1);
  bhc_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] rs_need, rt_need, need;
  logic rs_fwd, rt_fwd, active, stall, resolve;
  bv_t bv;
  assign bv = bv_t'(branch_variant);
  branch_src_hazard u_rs (
    .used(bv_uses_rs(bv)), .src(id_rs),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_write_reg(ex_write_reg),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_write_reg(mem_write_reg),
    .need(rs_need), .fwd(rs_fwd)
  );
  branch_src_hazard u_rt (
    .used(bv_uses_rt(bv)), .src(id_rt),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_write_reg(ex_write_reg),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_write_reg(mem_write_reg),
    .need(rt_need), .fwd(rt_fwd)
  );
  always_comb begin
    need    = rs_need > rt_need ? rs_need : rt_need;
    active  = rst_n && bv != BV_NONE;
    stall   = active && (state == BHC_STALL || need != 2'd0);
    resolve = active && state == BHC_IDLE && need == 2'd0;
    state_n = state;
    cnt_n   = cnt;
    if (state == BHC_IDLE && stall) begin
      cnt_n   = CW'(need - 2'd1);
      state_n = need > 2'd1 ? BHC_STALL : BHC_IDLE;
    end else if (state == BHC_STALL) begin
      cnt_n   = active ? cnt - CW'(1) : CW'(0);
      state_n = active && cnt > CW'(1) ? BHC_STALL : BHC_IDLE;
    end
  end
  assign stall_f  = stall;
  assign stall_d  = stall;
  assign flush_e  = stall;
  assign flush_d  = resolve & pc_src;
  assign fwd_rs_d = resolve & rs_fwd;
  assign fwd_rt_d = resolve & rt_fwd;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BHC_IDLE;
      cnt        <= '0;
      branch_cnt <= '0;
      taken_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (resolve && branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
      if (resolve && pc_src && taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: scoreboard bench for branch_hazard_ctrl control outputs and counters
module tb_branch_hazard_ctrl;
  import branch_hazard_ctrl_pkg::*;
  typedef struct packed {
    logic       rst;
    logic [2:0] bv;
    logic [4:0] rs, rt;
    logic       pc;
    logic       exw, exl;
    logic [4:0] exd;
    logic       mw, ml;
    logic [4:0] md;
    logic [5:0] ctl;
  } stim_t;
  logic clk = 1'b0, rst_n = 1'b0, pc_src = 1'b0;
  logic [2:0] branch_variant = 3'd0;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_write_reg = 5'd0, mem_write_reg = 5'd0;
  logic ex_reg_write = 1'b0, ex_mem_to_reg = 1'b0, mem_reg_write = 1'b0, mem_mem_to_reg = 1'b0;
  logic stall_f, stall_d, flush_e, flush_d, fwd_rs_d, fwd_rt_d;
  logic [31:0] branch_cnt, taken_cnt, stall_cnt;
  logic s_stall_f, s_stall_d, s_flush_e, s_flush_d, s_fwd_rs_d, s_fwd_rt_d;
  logic [3:0] s_branch_cnt, s_taken_cnt, s_stall_cnt;
  logic [5:0] ctl, e;
  logic [5:0] exp_q[$];
  logic [31:0] eb, et, es;
  int checks = 0, passed = 0;
  always #5 clk = ~clk;
  assign ctl = {stall_f, stall_d, flush_e, flush_d, fwd_rs_d, fwd_rt_d};
  branch_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .branch_variant(branch_variant), .id_rs(id_rs), .id_rt(id_rt),
    .pc_src(pc_src), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_write_reg(ex_write_reg), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_write_reg(mem_write_reg), .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .flush_d(flush_d), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .branch_cnt(branch_cnt),
    .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );
  branch_hazard_ctrl #(.CNT_W(4)) sat (
    .clk(clk), .rst_n(rst_n), .branch_variant(branch_variant), .id_rs(id_rs), .id_rt(id_rt),
    .pc_src(pc_src), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_write_reg(ex_write_reg), .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
    .mem_write_reg(mem_write_reg), .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_e(s_flush_e),
    .flush_d(s_flush_d), .fwd_rs_d(s_fwd_rs_d), .fwd_rt_d(s_fwd_rt_d), .branch_cnt(s_branch_cnt),
    .taken_cnt(s_taken_cnt), .stall_cnt(s_stall_cnt)
  );
  function automatic stim_t mk(logic r, bv_t bv, logic [4:0] rs, logic [4:0] rt, logic pc,
                               logic exw, logic exl, logic [4:0] exd,
                               logic mw, logic ml, logic [4:0] md, logic [5:0] c);
    return '{rst: r, bv: bv, rs: rs, rt: rt, pc: pc, exw: exw, exl: exl, exd: exd,
             mw: mw, ml: ml, md: md, ctl: c};
  endfunction
  task automatic apply(input stim_t s);
    @(negedge clk);
    rst_n = s.rst; branch_variant = s.bv; id_rs = s.rs; id_rt = s.rt; pc_src = s.pc;
    ex_reg_write = s.exw; ex_mem_to_reg = s.exl; ex_write_reg = s.exd;
    mem_reg_write = s.mw; mem_mem_to_reg = s.ml; mem_write_reg = s.md;
    exp_q.push_back(s.ctl);
    #4;
  endtask
  task automatic test_reset();
    stim_t v[$];
    v.push_back(mk(0, BV_BEQ, 8, 9, 1, 1, 0, 8, 0, 0, 0, 6'b000000));
    foreach (v[i]) begin
      apply(v[i]); e = exp_q.pop_front(); checks++;
      if (ctl !== e) $display("FAIL reset ctl cyc%0d got=%b want=%b", i, ctl, e); else passed++;
    end
    @(posedge clk); #1;
    eb = 0; et = 0; es = 0; checks++;
    if ({branch_cnt, taken_cnt, stall_cnt} !== {eb, et, es})
      $display("FAIL reset cnt got=%0d/%0d/%0d want=%0d/%0d/%0d", branch_cnt, taken_cnt, stall_cnt, eb, et, es);
    else passed++;
  endtask
  task automatic test_beq_forward();
    stim_t v[$];
    v.push_back(mk(1, BV_BEQ, 8, 9, 0, 1, 0, 8, 0, 0, 0, 6'b111000));
    v.push_back(mk(1, BV_BEQ, 8, 9, 1, 0, 0, 0, 1, 0, 8, 6'b000110));
    v.push_back(mk(1, BV_NONE, 8, 9, 1'bx, 0, 0, 0, 0, 0, 0, 6'b000000));
    foreach (v[i]) begin
      apply(v[i]); e = exp_q.pop_front(); checks++;
      if (ctl !== e) $display("FAIL beq_fwd ctl cyc%0d got=%b want=%b", i, ctl, e); else passed++;
    end
    @(posedge clk); #1;
    eb += 1; et += 1; es += 1; checks++;
    if ({branch_cnt, taken_cnt, stall_cnt} !== {eb, et, es})
      $display("FAIL beq_fwd cnt got=%0d/%0d/%0d want=%0d/%0d/%0d", branch_cnt, taken_cnt, stall_cnt, eb, et, es);
    else passed++;
  endtask
  task automatic test_load_stall();
    stim_t v[$];
    v.push_back(mk(1, BV_BNE, 3, 5, 0, 1, 1, 5, 0, 0, 0, 6'b111000));
    v.push_back(mk(1, BV_BNE, 3, 5, 0, 0, 0, 0, 1, 1, 5, 6'b111000));
    v.push_back(mk(1, BV_BNE, 3, 5, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    v.push_back(mk(1, BV_BNE, 3, 4, 1, 0, 0, 0, 1, 0, 4, 6'b000101));
    v.push_back(mk(1, BV_JUMP_REG, 12, 12, 1, 0, 0, 0, 1, 1, 12, 6'b111000));
    v.push_back(mk(1, BV_JUMP_REG, 12, 12, 1, 0, 0, 0, 0, 0, 0, 6'b000100));
    foreach (v[i]) begin
      apply(v[i]); e = exp_q.pop_front(); checks++;
      if (ctl !== e) $display("FAIL load_stall ctl cyc%0d got=%b want=%b", i, ctl, e); else passed++;
    end
    @(posedge clk); #1;
    eb += 3; et += 2; es += 3; checks++;
    if ({branch_cnt, taken_cnt, stall_cnt} !== {eb, et, es})
      $display("FAIL load_stall cnt got=%0d/%0d/%0d want=%0d/%0d/%0d", branch_cnt, taken_cnt, stall_cnt, eb, et, es);
    else passed++;
  endtask
  task automatic test_no_hazard();
    stim_t v[$];
    v.push_back(mk(1, BV_BLTZ, 0, 0, 1, 1, 0, 0, 0, 0, 0, 6'b000100));
    v.push_back(mk(1, BV_JUMP, 7, 7, 1, 1, 1, 7, 0, 0, 0, 6'b000100));
    v.push_back(mk(1, BV_BEQ, 6, 2, 0, 1, 0, 6, 1, 0, 6, 6'b111000));
    v.push_back(mk(1, BV_BEQ, 6, 2, 0, 0, 0, 0, 1, 0, 6, 6'b000010));
    foreach (v[i]) begin
      apply(v[i]); e = exp_q.pop_front(); checks++;
      if (ctl !== e) $display("FAIL no_hazard ctl cyc%0d got=%b want=%b", i, ctl, e); else passed++;
    end
    @(posedge clk); #1;
    eb += 3; et += 2; es += 1; checks++;
    if ({branch_cnt, taken_cnt, stall_cnt} !== {eb, et, es})
      $display("FAIL no_hazard cnt got=%0d/%0d/%0d want=%0d/%0d/%0d", branch_cnt, taken_cnt, stall_cnt, eb, et, es);
    else passed++;
  endtask
  task automatic test_stall_none();
    stim_t v[$];
    v.push_back(mk(1, BV_BNE, 1, 5, 0, 1, 1, 5, 0, 0, 0, 6'b111000));
    v.push_back(mk(1, BV_NONE, 1, 5, 1'bx, 0, 0, 0, 1, 1, 5, 6'b000000));
    v.push_back(mk(1, BV_BEQ, 1, 5, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    foreach (v[i]) begin
      apply(v[i]); e = exp_q.pop_front(); checks++;
      if (ctl !== e) $display("FAIL stall_none ctl cyc%0d got=%b want=%b", i, ctl, e); else passed++;
    end
    @(posedge clk); #1;
    eb += 1; es += 1; checks++;
    if ({branch_cnt, taken_cnt, stall_cnt} !== {eb, et, es})
      $display("FAIL stall_none cnt got=%0d/%0d/%0d want=%0d/%0d/%0d", branch_cnt, taken_cnt, stall_cnt, eb, et, es);
    else passed++;
  endtask
  task automatic test_reset_mid_stall();
    stim_t v[$];
    v.push_back(mk(1, BV_BNE, 1, 5, 0, 1, 1, 5, 0, 0, 0, 6'b111000));
    v.push_back(mk(0, BV_BNE, 1, 5, 0, 0, 0, 0, 1, 1, 5, 6'b000000));
    v.push_back(mk(1, BV_BNE, 1, 5, 0, 0, 0, 0, 1, 1, 5, 6'b111000));
    v.push_back(mk(1, BV_BNE, 1, 5, 1, 0, 0, 0, 0, 0, 0, 6'b000100));
    foreach (v[i]) begin
      apply(v[i]); e = exp_q.pop_front(); checks++;
      if (ctl !== e) $display("FAIL reset_mid ctl cyc%0d got=%b want=%b", i, ctl, e); else passed++;
      if (i == 1) begin
        @(posedge clk); #1;
        eb = 0; et = 0; es = 0; checks++;
        if ({branch_cnt, taken_cnt, stall_cnt} !== {eb, et, es})
          $display("FAIL reset_mid clr got=%0d/%0d/%0d want=0/0/0", branch_cnt, taken_cnt, stall_cnt);
        else passed++;
      end
    end
    @(posedge clk); #1;
    eb += 1; et += 1; es += 1; checks++;
    if ({branch_cnt, taken_cnt, stall_cnt} !== {eb, et, es})
      $display("FAIL reset_mid cnt got=%0d/%0d/%0d want=%0d/%0d/%0d", branch_cnt, taken_cnt, stall_cnt, eb, et, es);
    else passed++;
  endtask
  task automatic test_saturate();
    stim_t v[$];
    v.push_back(mk(0, BV_NONE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000));
    for (int k = 0; k < 20; k++) v.push_back(mk(1, BV_JUMP, 0, 0, 1, 0, 0, 0, 0, 0, 0, 6'b000100));
    foreach (v[i]) begin
      apply(v[i]); e = exp_q.pop_front(); checks++;
      if (ctl !== e) $display("FAIL saturate ctl cyc%0d got=%b want=%b", i, ctl, e); else passed++;
    end
    @(posedge clk); #1;
    checks++;
    if ({s_branch_cnt, s_taken_cnt, s_stall_cnt} !== {4'd15, 4'd15, 4'd0})
      $display("FAIL saturate cnt4 got=%0d/%0d/%0d want=15/15/0", s_branch_cnt, s_taken_cnt, s_stall_cnt);
    else passed++;
    eb = 20; et = 20; es = 0; checks++;
    if ({branch_cnt, taken_cnt, stall_cnt} !== {eb, et, es})
      $display("FAIL saturate cnt32 got=%0d/%0d/%0d want=%0d/%0d/%0d", branch_cnt, taken_cnt, stall_cnt, eb, et, es);
    else passed++;
  endtask
  initial begin
    test_reset();
    test_beq_forward();
    test_load_stall();
    test_no_hazard();
    test_stall_none();
    test_reset_mid_stall();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
